// File: rtl/cart_mem_bridge.sv
// Purpose : bridges cartridge-style ROM/RAM CPU strobes onto a single req/ack memory port (RAM mapped at 0x20000).
// Latency : start sampled at N -> MEM_REQ at N+1; MEM_ACK at M -> DO valid and BUSY low at M+1 (2 cycles minimum).
// Backpr. : MEM_REQ and its address/data are held until MEM_ACK; one access per strobe interval, ROM writes dropped.
module cart_mem_bridge (
  input  logic        CLK,
  input  logic        RES,
  input  logic [16:0] ROM_A,
  input  logic        ROM_CSB,
  input  logic [12:0] RAM_A,
  input  logic        RAM_CSB,
  input  logic        RDB,
  input  logic        WRB,
  input  logic [7:0]  DI,
  output logic [7:0]  DO,
  output logic        BUSY,
  output logic [17:0] MEM_A,
  output logic [7:0]  MEM_DO,
  output logic        MEM_WE,
  output logic        MEM_REQ,
  input  logic        MEM_ACK,
  input  logic [7:0]  MEM_DI
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        active_q;
  logic [17:0] mem_a_q, mem_a_d;
  logic [7:0]  mem_do_q, mem_do_d;
  logic        mem_we_q, mem_we_d;
  logic        mem_req_q, mem_req_d;
  logic        is_rd_q, is_rd_d;
  logic [7:0]  do_q, do_d;

  // Select / strobe decode: ROM select wins over RAM, read strobe wins over write.
  logic sel_rom, sel_ram, rd, wr, active, start;

  assign sel_rom = ~ROM_CSB;
  assign sel_ram = ~RAM_CSB & ROM_CSB;
  assign rd      = ~RDB;
  assign wr      = ~WRB & RDB;
  assign active  = (sel_rom | sel_ram) & (rd | wr);
  // active_q resets high so a strobe already held through reset never counts as a fresh start.
  assign start   = active & ~active_q;

  // Next-state and latched-request logic; every target defaults to holding its value.
  always_comb begin
    state_d   = state_q;
    mem_a_d   = mem_a_q;
    mem_do_d  = mem_do_q;
    mem_we_d  = mem_we_q;
    is_rd_d   = is_rd_q;
    do_d      = do_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (sel_rom && wr) begin
            // ROM write: nothing to do on the memory side, just wait out the strobe.
            state_d = S_HOLD;
          end else begin
            state_d  = S_REQ;
            mem_a_d  = sel_rom ? {1'b0, ROM_A} : {5'b10000, RAM_A};
            mem_do_d = DI;
            mem_we_d = sel_ram & wr;
            is_rd_d  = rd;
          end
        end
      end
      S_REQ: begin
        // The access runs to completion even if the CPU strobe has already gone away.
        if (MEM_ACK) begin
          if (is_rd_q) begin
            do_d = MEM_DI;
          end
          mem_we_d = 1'b0;
          state_d  = active ? S_HOLD : S_IDLE;
        end
      end
      S_HOLD: begin
        if (!active) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    mem_req_d = (state_d == S_REQ);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RES) begin
      state_q   <= S_IDLE;
      active_q  <= 1'b1;
      mem_a_q   <= '0;
      mem_do_q  <= '0;
      mem_we_q  <= 1'b0;
      mem_req_q <= 1'b0;
      is_rd_q   <= 1'b0;
      do_q      <= '0;
    end else begin
      state_q   <= state_d;
      active_q  <= active;
      mem_a_q   <= mem_a_d;
      mem_do_q  <= mem_do_d;
      mem_we_q  <= mem_we_d;
      mem_req_q <= mem_req_d;
      is_rd_q   <= is_rd_d;
      do_q      <= do_d;
    end
  end

  assign MEM_A   = mem_a_q;
  assign MEM_DO  = mem_do_q;
  assign MEM_WE  = mem_we_q;
  assign MEM_REQ = mem_req_q;
  assign BUSY    = (state_q == S_REQ);
  assign DO      = do_q;

endmodule

// File: tb/tb_cart_mem_bridge.sv
// Purpose : table-driven and hand-sequenced checks of cart_mem_bridge with a DO scoreboard queue.
// Latency : inputs driven and outputs sampled on the falling clock edge.
// Backpr. : the bench plays the memory side, acking after a per-vector delay.
module tb_cart_mem_bridge;

  logic        CLK = 1'b0;
  logic        RES;
  logic [16:0] ROM_A;
  logic        ROM_CSB;
  logic [12:0] RAM_A;
  logic        RAM_CSB;
  logic        RDB;
  logic        WRB;
  logic [7:0]  DI;
  logic [7:0]  DO;
  logic        BUSY;
  logic [17:0] MEM_A;
  logic [7:0]  MEM_DO;
  logic        MEM_WE;
  logic        MEM_REQ;
  logic        MEM_ACK;
  logic [7:0]  MEM_DI;

  always #5 CLK = ~CLK;

  cart_mem_bridge dut (
    .CLK(CLK), .RES(RES),
    .ROM_A(ROM_A), .ROM_CSB(ROM_CSB), .RAM_A(RAM_A), .RAM_CSB(RAM_CSB),
    .RDB(RDB), .WRB(WRB), .DI(DI),
    .DO(DO), .BUSY(BUSY),
    .MEM_A(MEM_A), .MEM_DO(MEM_DO), .MEM_WE(MEM_WE), .MEM_REQ(MEM_REQ),
    .MEM_ACK(MEM_ACK), .MEM_DI(MEM_DI)
  );

  typedef struct {
    logic        rom_csb;
    logic        ram_csb;
    logic        rdb;
    logic        wrb;
    logic [16:0] rom_a;
    logic [12:0] ram_a;
    logic [7:0]  di;
    logic [7:0]  mem_di;
    int          ack_dly;
    logic        exp_req;
    logic [17:0] exp_a;
    logic        exp_we;
    logic        exp_rd;
  } vec_t;

  localparam int NV = 9;
  vec_t        vt [NV];
  int          n_vec  = 0;
  int          n_miss = 0;
  logic [7:0]  exp_q [$];
  logic [7:0]  model_do;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_do(input string name);
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL %s: scoreboard empty, DO=0x%0h", name, DO);
    end else begin
      e = exp_q.pop_front();
      chk(name, {24'h0, DO}, {24'h0, e});
    end
  endtask

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic release_bus();
    ROM_CSB = 1'b1;
    RAM_CSB = 1'b1;
    RDB     = 1'b1;
    WRB     = 1'b1;
  endtask

  // Drives ROM_CSB low with RDB following pat bit-per-cycle, acks every request at once, counts requests.
  task automatic run_pattern(input logic [15:0] pat, input int ncyc, input logic [7:0] dat, output int nreq);
    logic prev;
    prev    = 1'b0;
    nreq    = 0;
    ROM_A   = 17'h0A0A0;
    ROM_CSB = 1'b0;
    MEM_DI  = dat;
    for (int c = 0; c < ncyc; c++) begin
      RDB = pat[c];
      tick();
      if (MEM_REQ && !prev) nreq++;
      prev    = MEM_REQ;
      MEM_ACK = MEM_REQ;
    end
    MEM_ACK = 1'b0;
    release_bus();
    tick();
    tick();
  endtask

  initial begin
    int nreq;
    vec_t v;

    //       csb_r csb_m rdb  wrb  rom_a      ram_a     di     mem_di dly req  exp_a       we   rd
    vt[0] = '{1'b0, 1'b1, 1'b0, 1'b1, 17'h1ABCD, 13'h0000, 8'h11, 8'h5A, 3, 1'b1, 18'h1ABCD, 1'b0, 1'b1};
    vt[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 17'h00000, 13'h1F80, 8'hC3, 8'hEE, 1, 1'b1, 18'h21F80, 1'b1, 1'b0};
    vt[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 17'h00010, 13'h0000, 8'h77, 8'h00, 0, 1'b0, 18'h00000, 1'b0, 1'b0};
    vt[3] = '{1'b1, 1'b0, 1'b0, 1'b1, 17'h00000, 13'h0000, 8'h00, 8'hA5, 0, 1'b1, 18'h20000, 1'b0, 1'b1};
    vt[4] = '{1'b0, 1'b1, 1'b0, 1'b1, 17'h1FFFF, 13'h0000, 8'h00, 8'h3C, 2, 1'b1, 18'h1FFFF, 1'b0, 1'b1};
    vt[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 17'h00123, 13'h1555, 8'h00, 8'h69, 1, 1'b1, 18'h00123, 1'b0, 1'b1};
    vt[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 17'h00000, 13'h1FFF, 8'h9F, 8'h96, 4, 1'b1, 18'h21FFF, 1'b0, 1'b1};
    vt[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 17'h00044, 13'h0AAA, 8'h55, 8'h00, 0, 1'b0, 18'h00000, 1'b0, 1'b0};
    vt[8] = '{1'b1, 1'b1, 1'b0, 1'b1, 17'h00001, 13'h0001, 8'h00, 8'h00, 0, 1'b0, 18'h00000, 1'b0, 1'b0};

    RES     = 1'b1;
    ROM_A   = '0;
    RAM_A   = '0;
    DI      = '0;
    MEM_ACK = 1'b0;
    MEM_DI  = '0;
    release_bus();
    tick(); tick(); tick();
    chk("rst_do",      {24'h0, DO},     32'h0);
    chk("rst_req",     {31'h0, MEM_REQ}, 32'h0);
    chk("rst_busy",    {31'h0, BUSY},   32'h0);
    chk("rst_mem_a",   {14'h0, MEM_A},  32'h0);
    chk("rst_mem_we",  {31'h0, MEM_WE}, 32'h0);
    chk("rst_mem_do",  {24'h0, MEM_DO}, 32'h0);
    RES = 1'b0;
    model_do = 8'h00;
    tick(); tick();

    // Table-driven single accesses.
    for (int i = 0; i < NV; i++) begin
      v = vt[i];
      if (v.exp_rd) model_do = v.mem_di;
      exp_q.push_back(model_do);
      ROM_CSB = v.rom_csb;
      RAM_CSB = v.ram_csb;
      RDB     = v.rdb;
      WRB     = v.wrb;
      ROM_A   = v.rom_a;
      RAM_A   = v.ram_a;
      DI      = v.di;
      tick();
      chk($sformatf("v%0d_req_start", i),  {31'h0, MEM_REQ}, {31'h0, v.exp_req});
      chk($sformatf("v%0d_busy_start", i), {31'h0, BUSY},    {31'h0, v.exp_req});
      if (v.exp_req) begin
        chk($sformatf("v%0d_mem_a", i),  {14'h0, MEM_A},  {14'h0, v.exp_a});
        chk($sformatf("v%0d_mem_we", i), {31'h0, MEM_WE}, {31'h0, v.exp_we});
        chk($sformatf("v%0d_mem_do", i), {24'h0, MEM_DO}, {24'h0, v.di});
        DI = ~v.di;
        for (int k = 0; k < v.ack_dly; k++) begin
          tick();
          chk($sformatf("v%0d_req_held", i), {31'h0, MEM_REQ}, 32'h1);
          chk($sformatf("v%0d_a_held", i),   {14'h0, MEM_A},   {14'h0, v.exp_a});
        end
        MEM_ACK = 1'b1;
        MEM_DI  = v.mem_di;
        tick();
        MEM_ACK = 1'b0;
        MEM_DI  = 8'($urandom);
        chk($sformatf("v%0d_req_done", i),  {31'h0, MEM_REQ}, 32'h0);
        chk($sformatf("v%0d_busy_done", i), {31'h0, BUSY},    32'h0);
        chk_do($sformatf("v%0d_do", i));
        tick();
        chk($sformatf("v%0d_hold_noreq", i), {31'h0, MEM_REQ}, 32'h0);
      end else begin
        for (int k = 0; k < 4; k++) begin
          tick();
          chk($sformatf("v%0d_no_req", i), {31'h0, MEM_REQ}, 32'h0);
        end
        chk_do($sformatf("v%0d_do_kept", i));
      end
      release_bus();
      tick();
      tick();
    end

    // Strobe released one cycle into the request; access still completes, then FSM is idle.
    RAM_A   = 13'h0123;
    RAM_CSB = 1'b0;
    RDB     = 1'b0;
    tick();
    chk("early_req",   {31'h0, MEM_REQ}, 32'h1);
    chk("early_mem_a", {14'h0, MEM_A},   32'h20123);
    RDB = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("early_req_held", {31'h0, MEM_REQ}, 32'h1);
    end
    MEM_ACK = 1'b1;
    MEM_DI  = 8'h42;
    tick();
    MEM_ACK = 1'b0;
    chk("early_req_done", {31'h0, MEM_REQ}, 32'h0);
    model_do = 8'h42;
    exp_q.push_back(model_do);
    chk_do("early_do");
    RDB = 1'b0;
    tick();
    chk("early_idle_restart", {31'h0, MEM_REQ}, 32'h1);
    MEM_ACK = 1'b1;
    MEM_DI  = 8'h24;
    tick();
    MEM_ACK = 1'b0;
    model_do = 8'h24;
    exp_q.push_back(model_do);
    chk_do("early_do2");
    release_bus();
    tick();
    tick();

    // Stray ack while idle must not touch DO.
    MEM_ACK = 1'b1;
    MEM_DI  = 8'hEE;
    tick();
    MEM_ACK = 1'b0;
    tick();
    exp_q.push_back(model_do);
    chk_do("stray_ack_do");
    chk("stray_ack_req", {31'h0, MEM_REQ}, 32'h0);

    // Reset during a request, strobe held throughout.
    ROM_A   = 17'h00055;
    ROM_CSB = 1'b0;
    RDB     = 1'b0;
    tick();
    chk("rstreq_req", {31'h0, MEM_REQ}, 32'h1);
    RES = 1'b1;
    tick();
    RES = 1'b0;
    chk("rstreq_req_drop", {31'h0, MEM_REQ}, 32'h0);
    chk("rstreq_mem_a",    {14'h0, MEM_A},   32'h0);
    model_do = 8'h00;
    exp_q.push_back(model_do);
    chk_do("rstreq_do_clr");
    MEM_ACK = 1'b1;
    MEM_DI  = 8'hFF;
    tick();
    MEM_ACK = 1'b0;
    exp_q.push_back(model_do);
    chk_do("rstreq_stray_ack");
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rstreq_held_noreq", {31'h0, MEM_REQ}, 32'h0);
    end
    release_bus();
    tick();
    tick();
    ROM_CSB = 1'b0;
    RDB     = 1'b0;
    tick();
    chk("rstreq_reassert_req", {31'h0, MEM_REQ}, 32'h1);
    chk("rstreq_reassert_a",   {14'h0, MEM_A},   32'h00055);
    MEM_ACK = 1'b1;
    MEM_DI  = 8'h3E;
    tick();
    MEM_ACK = 1'b0;
    model_do = 8'h3E;
    exp_q.push_back(model_do);
    chk_do("rstreq_reassert_do");
    release_bus();
    tick();
    tick();

    // Two reads split by exactly one inactive cycle, then one long strobe.
    run_pattern(16'hFF88, 12, 8'h81, nreq);
    chk("b2b_two_reqs", nreq, 2);
    model_do = 8'h81;
    exp_q.push_back(model_do);
    chk_do("b2b_do");
    run_pattern(16'hFC00, 12, 8'h18, nreq);
    chk("long_one_req", nreq, 1);
    model_do = 8'h18;
    exp_q.push_back(model_do);
    chk_do("long_do");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
